// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row drive, column debounce, row*COLS+col encoding,
// and a first-word-fall-through key-code queue with a valid/ready consumer port.
//
// state    | meaning
// SCAN     | current row held low; settle ticks, then evaluate columns
// DB_PRESS | captured column must stay low for DEBOUNCE_TICKS ticks
// EMIT     | one clock: push the key code (or flag overflow)
// WAIT_REL | key still held; wait for all columns high
// DB_REL   | all columns must stay high for DEBOUNCE_TICKS ticks
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 3,
  parameter int CLK_DIV        = 500000,
  parameter int SETTLE_TICKS   = 2,
  parameter int DEBOUNCE_TICKS = 3,
  parameter int FIFO_DEPTH     = 4,
  localparam int CODE_W        = $clog2(ROWS*COLS),
  localparam int FCNT_W        = $clog2(FIFO_DEPTH)+1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [COLS-1:0]   cols,
  output logic [ROWS-1:0]   rows,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [FCNT_W-1:0] fifo_count,
  output logic              overflow,
  input  logic              clear_overflow
);

  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);
  localparam int DW   = $clog2(CLK_DIV);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TMAX = (SETTLE_TICKS > DEBOUNCE_TICKS) ? SETTLE_TICKS : DEBOUNCE_TICKS;
  localparam int TW   = $clog2(TMAX+1);

  typedef enum logic [2:0] {SCAN, DB_PRESS, EMIT, WAIT_REL, DB_REL} state_t;

  state_t              state;
  logic [COLS-1:0]     cols_meta, cols_sync;
  logic [DW-1:0]       div_cnt;
  logic                tick;
  logic [RW-1:0]       row_idx, row_next;
  logic [CW-1:0]       col_idx, low_col;
  logic                any_low, all_high, col_low;
  logic [TW-1:0]       tcnt;
  logic [CODE_W-1:0]   code_emit;
  logic [CODE_W-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                push, pop, full, wr_en;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cols_meta <= '1;
      cols_sync <= '1;
    end else begin
      cols_meta <= cols;
      cols_sync <= cols_meta;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)           div_cnt <= '0;
    else if (div_cnt == '0) div_cnt <= DW'(CLK_DIV-1);
    else                    div_cnt <= div_cnt - 1'b1;
  end
  assign tick = (div_cnt == '0);

  // Lowest-index closed column wins when several keys in a row are down.
  always_comb begin
    low_col = '0;
    any_low = 1'b0;
    for (int c = COLS-1; c >= 0; c--) begin
      if (!cols_sync[c]) begin
        low_col = CW'(c);
        any_low = 1'b1;
      end
    end
  end

  assign all_high  = &cols_sync;
  assign col_low   = ~cols_sync[col_idx];
  assign row_next  = (row_idx == RW'(ROWS-1)) ? '0 : row_idx + 1'b1;
  assign code_emit = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col_idx);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= SCAN;
      row_idx <= '0;
      col_idx <= '0;
      tcnt    <= '0;
      rows    <= '1;
    end else begin
      rows <= ~(ROWS'(1) << row_idx);
      case (state)
        SCAN: if (tick) begin
          if (tcnt != TW'(SETTLE_TICKS)) begin
            tcnt <= tcnt + 1'b1;
          end else begin
            tcnt <= '0;
            if (any_low) begin
              col_idx <= low_col;
              state   <= DB_PRESS;
            end else begin
              row_idx <= row_next;
            end
          end
        end
        DB_PRESS: if (tick) begin
          if (!col_low) begin
            tcnt    <= '0;
            row_idx <= row_next;
            state   <= SCAN;
          end else if (tcnt == TW'(DEBOUNCE_TICKS-1)) begin
            tcnt  <= '0;
            state <= EMIT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        EMIT: state <= WAIT_REL;
        WAIT_REL: if (tick && all_high) begin
          tcnt  <= '0;
          state <= DB_REL;
        end
        DB_REL: if (tick) begin
          if (!all_high) begin
            tcnt  <= '0;
            state <= WAIT_REL;
          end else if (tcnt == TW'(DEBOUNCE_TICKS-1)) begin
            tcnt    <= '0;
            row_idx <= row_next;
            state   <= SCAN;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full queue still lands.
  assign push      = (state == EMIT);
  assign key_valid = (fifo_count != '0);
  assign pop       = key_valid & key_ready;
  assign full      = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign wr_en     = push & (~full | pop);
  assign key_code  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= code_emit;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
      else if (clear_overflow)  overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model closes the selected key's
// column whenever its row is driven low; each task checks one scenario.
module tb_keypad_scanner;

  localparam int ROWS = 4;
  localparam int COLS = 3;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [COLS-1:0]  cols;
  logic [ROWS-1:0]  rows;
  logic [3:0]       key_code;
  logic             key_valid;
  logic             key_ready;
  logic [2:0]       fifo_count;
  logic             overflow;
  logic             clear_overflow;

  int               press_row;
  logic [COLS-1:0]  press_mask;
  logic             press_en;
  int               popped[$];
  int               checks = 0;
  int               errors = 0;

  keypad_scanner #(
    .ROWS(4), .COLS(3), .CLK_DIV(4), .SETTLE_TICKS(2),
    .DEBOUNCE_TICKS(3), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .cols(cols), .rows(rows),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clear_overflow(clear_overflow)
  );

  always #5 clock = ~clock;

  always_comb begin
    cols = '1;
    if (press_en && !rows[press_row]) cols = ~press_mask;
  end

  always @(posedge clock)
    if (reset_n && key_valid && key_ready) popped.push_back(int'(key_code));

  task automatic wait_rows(input logic [3:0] v, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (rows == v) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rows_not(input logic [3:0] v, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (rows != v) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pop(input int target, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clock);
      if (popped.size() >= target) begin ok = 1'b1; break; end
    end
  endtask

  // Press a key until it is accepted (queued, popped or dropped), then release
  // it and wait for the scanner to leave its row.
  task automatic press_and_release(input int r, input logic [2:0] mask, output bit ok);
    logic [2:0] c0;
    logic       ov0;
    int         p0;
    logic [3:0] rv;
    bit         ok2;
    c0 = fifo_count; ov0 = overflow; p0 = popped.size();
    rv = ~(4'b0001 << r);
    press_row = r; press_mask = mask; press_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (fifo_count != c0 || (overflow && !ov0) || popped.size() != p0) begin
        ok = 1'b1; break;
      end
    end
    press_en = 1'b0;
    wait_rows_not(rv, 200, ok2);
    ok = ok & ok2;
  endtask

  task automatic test_reset;
    bit ok;
    reset_n = 1'b0; key_ready = 1'b0; clear_overflow = 1'b0; press_en = 1'b0;
    press_row = 0; press_mask = '0;
    repeat (3) @(negedge clock);
    checks++; if (rows !== 4'b1111) begin errors++; $display("FAIL reset_rows got %b want 1111", rows); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code got %0d want 0", key_code); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    reset_n = 1'b1;
    wait_rows(4'b1110, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL reset_scan_row0 got %b want 1110", rows); end
  endtask

  task automatic test_single_press;
    bit ok;
    int p0;
    key_ready = 1'b1; p0 = popped.size();
    press_row = 2; press_mask = 3'b010; press_en = 1'b1;
    wait_pop(p0 + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d pops want %0d", popped.size(), p0 + 1); end
    checks++; if (ok && popped[p0] !== 7) begin errors++; $display("FAIL single_code got %0d want 7", popped[p0]); end
    repeat (40) @(negedge clock);
    checks++; if (rows !== 4'b1011) begin errors++; $display("FAIL single_hold_row got %b want 1011", rows); end
    checks++; if (popped.size() != p0 + 1) begin errors++; $display("FAIL single_no_repeat got %0d pops want %0d", popped.size(), p0 + 1); end
    press_en = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (rows !== 4'b1011) begin errors++; $display("FAIL single_release_hold got %b want 1011", rows); end
    wait_rows(4'b0111, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_next_row got %b want 0111", rows); end
    checks++; if (popped.size() != p0 + 1) begin errors++; $display("FAIL single_one_transfer got %0d want %0d", popped.size(), p0 + 1); end
  endtask

  task automatic test_glitch;
    bit ok, ok2;
    int p0;
    key_ready = 1'b1; p0 = popped.size(); press_en = 1'b0;
    wait_rows_not(4'b1110, 100, ok);
    wait_rows(4'b1110, 100, ok2);
    checks++; if (!(ok && ok2)) begin errors++; $display("FAIL glitch_find_row0 got %b want 1110", rows); end
    repeat (8) @(negedge clock);
    press_row = 0; press_mask = 3'b001; press_en = 1'b1;
    repeat (4) @(negedge clock);
    press_en = 1'b0;
    wait_rows(4'b1101, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL glitch_next_row got %b want 1101", rows); end
    repeat (4) @(negedge clock);
    checks++; if (popped.size() != p0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL glitch_no_code got pops %0d count %0d want pops %0d count 0", popped.size(), fifo_count, p0);
    end
  endtask

  task automatic test_overflow;
    int         r_tab[5]    = '{0, 1, 2, 3, 0};
    logic [2:0] m_tab[5]    = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
    int         cnt_tab[5]  = '{1, 2, 3, 4, 4};
    logic       ov_tab[5]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int         code_tab[4] = '{0, 4, 8, 11};
    bit ok;
    int p0;
    key_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      press_and_release(r_tab[i], m_tab[i], ok);
      checks++; if (!ok) begin errors++; $display("FAIL ovf_press%0d_timeout got rows %b", i, rows); end
      checks++; if (int'(fifo_count) != cnt_tab[i]) begin errors++; $display("FAIL ovf_count%0d got %0d want %0d", i, fifo_count, cnt_tab[i]); end
      checks++; if (overflow !== ov_tab[i]) begin errors++; $display("FAIL ovf_flag%0d got %b want %b", i, overflow, ov_tab[i]); end
    end
    p0 = popped.size();
    key_ready = 1'b1;
    repeat (8) @(negedge clock);
    checks++; if (popped.size() != p0 + 4) begin errors++; $display("FAIL ovf_drain_count got %0d want %0d", popped.size() - p0, 4); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (popped.size() > p0 + k && popped[p0 + k] != code_tab[k]) begin
        errors++; $display("FAIL ovf_drain_code%0d got %0d want %0d", k, popped[p0 + k], code_tab[k]);
      end
    end
    checks++; if (fifo_count !== 3'd0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_empty got count %0d valid %b want 0 0", fifo_count, key_valid);
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_release_bounce;
    bit ok;
    int p0;
    key_ready = 1'b1; p0 = popped.size();
    press_row = 1; press_mask = 3'b001; press_en = 1'b1;
    wait_pop(p0 + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_timeout got %0d pops want %0d", popped.size(), p0 + 1); end
    checks++; if (ok && popped[p0] !== 3) begin errors++; $display("FAIL bounce_code got %0d want 3", popped[p0]); end
    for (int k = 0; k < 4; k++) begin
      press_en = (k % 2 == 1);
      repeat (4) @(negedge clock);
      checks++; if (rows !== 4'b1101) begin errors++; $display("FAIL bounce_hold%0d got %b want 1101", k, rows); end
    end
    press_en = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (rows !== 4'b1101) begin errors++; $display("FAIL bounce_settle got %b want 1101", rows); end
    wait_rows(4'b1011, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bounce_next_row got %b want 1011", rows); end
    checks++; if (popped.size() != p0 + 1) begin errors++; $display("FAIL bounce_single got %0d pops want %0d", popped.size(), p0 + 1); end
  endtask

  task automatic test_two_cols;
    bit ok;
    int p0;
    key_ready = 1'b1; p0 = popped.size();
    press_and_release(3, 3'b101, ok);
    checks++; if (!ok) begin errors++; $display("FAIL twocol_timeout got rows %b", rows); end
    repeat (2) @(negedge clock);
    checks++; if (popped.size() != p0 + 1) begin errors++; $display("FAIL twocol_count got %0d want %0d", popped.size(), p0 + 1); end
    checks++; if (popped.size() > p0 && popped[p0] != 9) begin errors++; $display("FAIL twocol_code got %0d want 9", popped[p0]); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    key_ready = 1'b0;
    press_and_release(0, 3'b010, ok);
    press_and_release(1, 3'b100, ok);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rstmid_count got %0d want 2", fifo_count); end
    checks++; if (key_valid !== 1'b1 || key_code !== 4'd1) begin
      errors++; $display("FAIL rstmid_head got valid %b code %0d want 1 1", key_valid, key_code);
    end
    press_row = 2; press_mask = 3'b001; press_en = 1'b1;
    wait_rows(4'b1011, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_find_row2 got %b want 1011", rows); end
    repeat (15) @(negedge clock);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL rstmid_pre_count got %0d want 2", fifo_count); end
    reset_n = 1'b0;
    #1;
    checks++; if (rows !== 4'b1111) begin errors++; $display("FAIL rstmid_rows got %b want 1111", rows); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", key_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rstmid_fifo got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0 || key_code !== 4'd0) begin
      errors++; $display("FAIL rstmid_ovf_code got ovf %b code %0d want 0 0", overflow, key_code);
    end
    press_en = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_rows(4'b1110, 5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_restart got %b want 1110", rows); end
  endtask

  initial begin
    test_reset;
    test_single_press;
    test_glitch;
    test_overflow;
    test_release_bounce;
    test_two_cols;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner: drives active-low rows, samples active-low columns, debounces both press and release, and encodes each key as row*COLS+col.
- Queues debounced key codes in a small FIFO and presents them on a valid/ready interface to the processor I/O path.
- Replaces single-shot acknowledge logic, so no keypress is lost while the processor is busy.

Parameters:
- ROWS, 4, number of row lines driven (2..8)
- COLS, 3, number of column lines sampled (2..8)
- CLK_DIV, 500000, clock cycles per scan tick (>=2); 100 Hz tick at 50 MHz
- SETTLE_TICKS, 2, ticks a row is held low before its columns are evaluated (>=1)
- DEBOUNCE_TICKS, 3, consecutive stable ticks required for both press and release (>=1)
- FIFO_DEPTH, 4, key-code queue entries (power of two, >=2)
- CODE_W, $clog2(ROWS*COLS), key-code width (derived; not overridden)

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cols  in  COLS  raw column inputs, active-low (0 = key closed), asynchronous to clock
- rows  out  ROWS  row drives; exactly one bit low while scanning, all high in reset
- key_code  out  CODE_W  code at FIFO head, row*COLS+col
- key_valid  out  1  FIFO non-empty
- key_ready  in  1  consumer accepts key_code this cycle
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued
- overflow  out  1  sticky; a debounced key was dropped because the FIFO was full
- clear_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (async assert, sync release): rows all 1, key_valid 0, key_code 0, fifo_count 0, overflow 0; FSM in SCAN, row index 0, all counters 0.
- cols pass through a 2-flop synchroniser; all evaluation uses the synchronised value, adding 2 clocks of latency.
- Tick: one-cycle pulse every CLK_DIV clocks from a free-running divider. All FSM timing advances only on ticks.
- SCAN: drive the current row low. After SETTLE_TICKS ticks, evaluate on the next tick.
  - No column low: advance to the next row (ROWS-1 wraps to 0) and restart settle.
  - Any column low: capture the lowest-index low column and go to DB_PRESS.
- DB_PRESS: keep the row held. Each tick where the captured column is low increments the count.
  - Captured column high: return to SCAN and advance to the next row; no code is emitted.
  - Count reaches DEBOUNCE_TICKS: go to EMIT.
- EMIT (one clock, not tick-gated): push row*COLS+col, then go to WAIT_REL.
  - If the FIFO is full, drop the code, set overflow, and still go to WAIT_REL.
- WAIT_REL: keep the row held. When all columns are high, go to DB_REL.
- DB_REL: count consecutive all-high ticks; any low column returns to WAIT_REL.
  - Count reaches DEBOUNCE_TICKS: advance to the next row and go to SCAN.
- One emit per physical press; holding a key produces no repeats.
- Simultaneous keys in one row: lowest column wins. Other rows are not scanned until release.
- FIFO is first-word fall-through.
  - key_code always equals the head entry while key_valid = 1.
  - A pop occurs on key_valid & key_ready. key_ready with an empty FIFO has no effect.
  - Push and pop in the same cycle: count unchanged, allowed even when full (pop frees the slot, push succeeds, no overflow).
  - Push on empty: key_valid rises the clock after EMIT.
- overflow stays set until clear_overflow. If clear and a new overflow coincide, set wins.
- reset_n asserted mid-debounce or mid-transfer: everything returns to reset values and queued codes are discarded.

Test Plan (CLK_DIV=4, SETTLE_TICKS=2, DEBOUNCE_TICKS=3, FIFO_DEPTH=4, ROWS=4, COLS=3):
- Row 2 / col 1 pressed (cols=3'b101 whenever rows[2]=0), held 10 ticks, key_ready=1 → exactly one transfer, key_code=7, rows[2] stays low until release is debounced.
- 1-tick glitch on col 0 during row 0 → DB_PRESS aborts, no code, scan proceeds to row 1.
- key_ready=0, five distinct presses (codes 0, 4, 8, 11, 2) → fifo_count=4, overflow=1 after the fifth; raising key_ready drains 0, 4, 8, 11 in order.
- Release bounce (cols toggling high/low every tick for 4 ticks, then high) → rows hold the same row until 3 stable high ticks; no second code.
- Columns 0 and 2 low together on row 3 → single code 9.
- reset_n pulsed low during DB_PRESS with 2 entries queued → immediately rows=4'b1111, key_valid=0, fifo_count=0, overflow=0; scan restarts at row 0.
